pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer that replaces the fixed 32-bit PC in the fetch stage. It produces the instruction-memory word address each cycle and supports stall, branch, call/return through a hardware return-address stack (RAS), and single-level interrupt entry/exit. All next-PC selection is registered, with one update per clock edge.

## Interface

Parameters:
- ADDR_W, 32: width of every address signal.
- STEP, 1: sequential increment, in words.
- RESET_VEC, 0: PC value after reset.
- IRQ_VEC, 32'h10: interrupt handler entry address.
- RAS_DEPTH, 4: return-address stack entries. Must be 2..16.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold all state this cycle.
- is_branch  in  1  load branch_addr.
- branch_addr  in  ADDR_W  branch/jump target.
- is_call  in  1  push return address, then load branch_addr.
- is_ret  in  1  pop the RAS into the PC.
- irq  in  1  level interrupt request.
- is_reti  in  1  return from interrupt.
- pc_out  out  ADDR_W  current PC.
- in_irq  out  1  the handler is active.
- ras_count  out  clog2(RAS_DEPTH+1)  valid RAS entries.
- ras_overflow  out  1  sticky: a push happened with the stack full.
- ras_underflow  out  1  sticky: a pop happened with the stack empty.

## Operation

- The next PC is chosen from the highest-priority event that applies, evaluated only when stall=0:
  1. irq=1 and in_irq=0: pc <= IRQ_VEC, epc <= pc_out, in_irq <= 1.
  2. is_reti=1 and in_irq=1: pc <= epc, in_irq <= 0.
  3. is_ret=1: pc <= RAS top, pop.
  4. is_call=1: push pc_out+STEP, pc <= branch_addr.
  5. is_branch=1: pc <= branch_addr.
  6. Otherwise: pc <= pc_out+STEP.
- Lower-priority requests arriving in the same cycle are dropped, not queued. irq is level-sensitive, so it is re-evaluated every cycle.
- is_reti with in_irq=0 is treated as no event, so the PC increments.
- While in_irq=1, irq is ignored; there is no nesting.
- The RAS is a circular buffer with a top pointer and a count.
- Push when full: the oldest entry is overwritten, count stays at RAS_DEPTH, and ras_overflow <= 1.
- Pop when empty: pc <= pc_out+STEP, count stays 0, and ras_underflow <= 1.
- Arithmetic is modulo 2^ADDR_W. pc_out+STEP wraps silently, including for the pushed return address.
- epc is internal and ADDR_W wide.
- stall=1 freezes pc_out, the RAS, epc, in_irq and the flags. All event inputs are ignored that cycle.

## Timing

- The register update happens on the rising clk edge. pc_out reflects an event one cycle after it is sampled.
- Zero-cycle paths: none from inputs to outputs; all outputs are registered.
- Asserting reset (low) immediately and asynchronously forces these values, including mid-call or mid-handler:
  - pc_out = RESET_VEC
  - in_irq = 0
  - epc = 0
  - ras_count = 0
  - RAS pointer = 0
  - ras_overflow = 0
  - ras_underflow = 0
- Deassertion is sampled synchronously. The first edge with reset=1 performs a normal update from RESET_VEC.
- RAS contents are not cleared by reset. Entries are unreadable until written because count=0.
- Back-to-back call/ret on consecutive cycles is supported at full rate.
- A call in cycle n followed by a ret in cycle n+1 returns to the cycle-n pc_out+STEP.
- Sticky flags clear only through reset.

## Test plan

- Reset and sequencing: hold reset low, then release with no events for 5 cycles -> pc_out = 0,1,2,3,4,5; ras_count = 0.
- Call/return nesting (RAS_DEPTH=4):
  - Calls at pc=2, 10, 20 to targets 10, 20, 30, then three rets.
  - Required: pc_out goes 31 -> 21 -> 11 -> 3 across the rets; ras_count 3 -> 0; no flags set.
- RAS overflow/underflow:
  - Five calls with no rets -> ras_overflow=1 and ras_count=4; five rets then pop the four newest return addresses.
  - The fifth ret gives pc = previous+1 and ras_underflow=1.
- Interrupt priority:
  - irq=1 together with is_call at pc=7 -> pc_out=16'h10, in_irq=1, ras_count unchanged.
  - irq held high inside the handler has no effect.
  - is_reti -> pc_out=7, in_irq=0.
- Stall and async reset:
  - stall=1 for 3 cycles with is_branch=1 and branch_addr=99 -> pc_out unchanged and the branch is lost.
  - Drive reset low between clock edges mid-handler -> pc_out=0 and in_irq=0 before the next edge.
- Wrap-around (ADDR_W=8, STEP=4): is_branch to 8'hFC -> next pc_out = 8'h00; a call at 8'hFC pushes 8'h00.

Source files
------------

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for the fetch stage. Each rising clock edge it
// picks one next-PC source by fixed priority: interrupt entry, interrupt
// return, subroutine return, call, branch, then sequential increment.
// Calls and returns use a hardware return-address stack (RAS). The RAS is a
// circular buffer: a push while full overwrites the oldest entry. There is a
// single level of interrupt, with the interrupted PC saved in an internal EPC.
//
// Parameters:
//   ADDR_W     width of every address signal
//   STEP       sequential increment in words
//   RESET_VEC  PC value after reset
//   IRQ_VEC    interrupt handler entry address
//   RAS_DEPTH  return-address stack entries (2..16)
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   stall          freeze all state this cycle and ignore every event input
//   is_branch      load branch_addr
//   branch_addr    branch / call target
//   is_call        push pc_out+STEP, then load branch_addr
//   is_ret         pop the RAS into the PC
//   irq            level-sensitive interrupt request
//   is_reti        return from interrupt
//   pc_out         current PC (registered)
//   in_irq         interrupt handler active (registered)
//   ras_count      number of valid RAS entries (registered)
//   ras_overflow   sticky: a push happened while the stack was full
//   ras_underflow  sticky: a pop happened while the stack was empty
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        STEP      = 1,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter logic [ADDR_W-1:0]  IRQ_VEC   = ADDR_W'(32'h10),
    parameter int unsigned        RAS_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall,
    input  logic                              is_branch,
    input  logic [ADDR_W-1:0]                 branch_addr,
    input  logic                              is_call,
    input  logic                              is_ret,
    input  logic                              irq,
    input  logic                              is_reti,
    output logic [ADDR_W-1:0]                 pc_out,
    output logic                              in_irq,
    output logic [$clog2(RAS_DEPTH+1)-1:0]    ras_count,
    output logic                              ras_overflow,
    output logic                              ras_underflow
);

    localparam int unsigned       PTR_W   = $clog2(RAS_DEPTH);
    localparam int unsigned       CNT_W   = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] STEP_W  = ADDR_W'(STEP);

    // Interrupt mode: a two-state machine, since handlers do not nest.
    typedef enum logic {
        MODE_RUN     = 1'b0,
        MODE_HANDLER = 1'b1
    } mode_e;

    // The single event that wins arbitration this cycle.
    typedef enum logic [2:0] {
        EV_HOLD,
        EV_IRQ,
        EV_RETI,
        EV_RET,
        EV_CALL,
        EV_BRANCH,
        EV_SEQ
    } event_e;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    mode_e             mode_q, mode_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;   // next free slot; top of stack is ptr_q-1
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];

    // ---------------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------------
    event_e            ev;
    logic [ADDR_W-1:0] pc_inc;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_full;
    logic              push_en;

    // Addition wraps modulo 2^ADDR_W, which also covers the pushed return
    // address.
    assign pc_inc    = pc_q + STEP_W;
    assign ptr_inc   = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
    assign ptr_dec   = (ptr_q == '0) ? PTR_MAX : ptr_q - 1'b1;
    assign ras_top   = ras_mem_q[ptr_dec];
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_MAX);

    // Priority arbitration. Losing requests are dropped, not queued.
    always_comb begin
        ev = EV_SEQ;
        if (stall) begin
            ev = EV_HOLD;
        end else if (irq && (mode_q == MODE_RUN)) begin
            ev = EV_IRQ;
        end else if (is_reti && (mode_q == MODE_HANDLER)) begin
            ev = EV_RETI;
        end else if (is_ret) begin
            ev = EV_RET;
        end else if (is_call) begin
            ev = EV_CALL;
        end else if (is_branch) begin
            ev = EV_BRANCH;
        end
    end

    // Next-state logic.
    // NOTE: every variable gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        mode_d  = mode_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;

        unique case (ev)
            EV_HOLD: begin
                // Everything keeps its value.
            end
            EV_IRQ: begin
                pc_d   = IRQ_VEC;
                epc_d  = pc_q;
                mode_d = MODE_HANDLER;
            end
            EV_RETI: begin
                pc_d   = epc_q;
                mode_d = MODE_RUN;
            end
            EV_RET: begin
                if (ras_empty) begin
                    // Nothing to return to: keep fetching sequentially.
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end else begin
                    pc_d  = ras_top;
                    ptr_d = ptr_dec;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            EV_CALL: begin
                push_en = 1'b1;
                pc_d    = branch_addr;
                ptr_d   = ptr_inc;
                if (ras_full) begin
                    // When full, the write slot is the oldest entry. It is
                    // overwritten and the count stays saturated.
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EV_BRANCH: begin
                pc_d = branch_addr;
            end
            default: begin
                pc_d = pc_inc;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= RESET_VEC;
            epc_q  <= '0;
            mode_q <= MODE_RUN;
            ptr_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            epc_q  <= epc_d;
            mode_q <= mode_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // NOTE: the stack storage has no reset. A count of zero already makes
    // stale entries unreachable, and leaving the storage unreset lets it map
    // to plain RAM or flops without a reset network.
    always_ff @(posedge clk) begin
        if (push_en) begin
            ras_mem_q[ptr_q] <= pc_inc;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: all taken directly from registers
    // ---------------------------------------------------------------------
    assign pc_out        = pc_q;
    assign in_irq        = (mode_q == MODE_HANDLER);
    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule
